ttt_board_ctrl: RTL and testbench



---
 rtl/ttt_board_ctrl_pkg.sv | 36 +++
 rtl/ttt_win_detect.sv | 31 +++
 rtl/ttt_board_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ttt_board_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_board_ctrl_pkg.sv
// Shared cell/error encodings, FSM state type and winning-line table for the tic-tac-toe board.
package ttt_board_ctrl_pkg;

  localparam int unsigned NumCells = 9;
  localparam int unsigned BoardW   = 2 * NumCells;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_X     = 2'd1;
  localparam logic [1:0] CELL_O     = 2'd2;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OCCUPIED = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_VALUE    = 3'd3;
  localparam logic [2:0] ERR_TURN     = 3'd4;
  localparam logic [2:0] ERR_OVER     = 3'd5;

  typedef enum logic [1:0] {
    StPlay,
    StCheck,
    StDone
  } state_e;

  // Rows, columns, then the two diagonals, as row-major cell indices.
  localparam logic [3:0] WinLines [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector: flags a win and reports the winning cell value.
module ttt_win_detect
  import ttt_board_ctrl_pkg::*;
(
  input  logic [BoardW-1:0] board_i,
  output logic              win_o,
  output logic [1:0]        winner_o
);

  logic [1:0] cells [NumCells];

  always_comb begin
    for (int i = 0; i < NumCells; i++) begin
      cells[i] = board_i[2*i +: 2];
    end
  end

  always_comb begin
    win_o    = 1'b0;
    winner_o = CELL_EMPTY;
    for (int l = 0; l < 8; l++) begin
      if ((cells[WinLines[l][0]] != CELL_EMPTY) &&
          (cells[WinLines[l][0]] == cells[WinLines[l][1]]) &&
          (cells[WinLines[l][0]] == cells[WinLines[l][2]])) begin
        win_o    = 1'b1;
        winner_o = cells[WinLines[l][0]];
      end
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe board controller: edge-detects submit, validates and applies moves, detects win/draw.
// Define TURN_CHECK_EN to enforce X/O alternation starting from FIRST_PLAYER.
module ttt_board_ctrl
  import ttt_board_ctrl_pkg::*;
#(
  parameter logic [1:0]  FIRST_PLAYER = CELL_X,
  parameter int unsigned NUM_CELLS    = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  update_loc,
  input  logic [1:0]  update_val,
  input  logic        submit,
  input  logic        game_reset,
  output logic [17:0] board,
  output logic        move_ok,
  output logic        move_err,
  output logic [2:0]  err_code,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner
);

  state_e            state_q, state_d;
  logic [BoardW-1:0] board_q, board_d;
  logic [3:0]        move_count_q, move_count_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              move_ok_q, move_ok_d;
  logic              move_err_q, move_err_d;
  logic              pending_q, pending_d;
  logic              submit_q;

`ifdef TURN_CHECK_EN
  logic [1:0]        turn_q, turn_d;
`else
  logic              unused_first_player;
  assign unused_first_player = ^FIRST_PLAYER;
`endif

  logic       sub_rise;
  logic       req;
  logic [1:0] cur_cell;
  logic [2:0] chk_err;
  logic       win;
  logic [1:0] win_val;

  assign sub_rise = submit & ~submit_q;
  assign req      = sub_rise | pending_q;

  ttt_win_detect u_win_detect (
    .board_i  (board_q),
    .win_o    (win),
    .winner_o (win_val)
  );

  // Move validation; earlier checks take priority.
  always_comb begin
    cur_cell = CELL_EMPTY;
    for (int i = 0; i < NumCells; i++) begin
      if (update_loc == 4'(i)) cur_cell = board_q[2*i +: 2];
    end
    chk_err = ERR_NONE;
    if (32'(update_loc) >= NUM_CELLS) begin
      chk_err = ERR_RANGE;
    end else if ((update_val != CELL_X) && (update_val != CELL_O)) begin
      chk_err = ERR_VALUE;
`ifdef TURN_CHECK_EN
    end else if (update_val != turn_q) begin
      chk_err = ERR_TURN;
`endif
    end else if (cur_cell != CELL_EMPTY) begin
      chk_err = ERR_OCCUPIED;
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    move_count_d = move_count_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    err_code_d   = err_code_q;
    move_ok_d    = 1'b0;
    move_err_d   = 1'b0;
    pending_d    = pending_q;
`ifdef TURN_CHECK_EN
    turn_d       = turn_q;
`endif

    if (game_reset) begin
      state_d      = StPlay;
      board_d      = '0;
      move_count_d = 4'd0;
      game_over_d  = 1'b0;
      winner_d     = CELL_EMPTY;
      err_code_d   = ERR_NONE;
      pending_d    = 1'b0;
`ifdef TURN_CHECK_EN
      turn_d       = FIRST_PLAYER;
`endif
    end else begin
      unique case (state_q)
        StPlay: begin
          if (req) begin
            pending_d = 1'b0;
            if (chk_err == ERR_NONE) begin
              for (int i = 0; i < NumCells; i++) begin
                if (update_loc == 4'(i)) board_d[2*i +: 2] = update_val;
              end
              move_count_d = move_count_q + 4'd1;
              move_ok_d    = 1'b1;
              err_code_d   = ERR_NONE;
              state_d      = StCheck;
`ifdef TURN_CHECK_EN
              turn_d       = (turn_q == CELL_X) ? CELL_O : CELL_X;
`endif
            end else begin
              move_err_d = 1'b1;
              err_code_d = chk_err;
            end
          end
        end
        StCheck: begin
          // An edge seen while evaluating is replayed on the next PLAY/DONE cycle.
          if (sub_rise) pending_d = 1'b1;
          if (win) begin
            game_over_d = 1'b1;
            winner_d    = win_val;
            state_d     = StDone;
          end else if (move_count_q == 4'(NumCells)) begin
            game_over_d = 1'b1;
            winner_d    = CELL_EMPTY;
            state_d     = StDone;
          end else begin
            state_d = StPlay;
          end
        end
        StDone: begin
          if (req) begin
            pending_d  = 1'b0;
            move_err_d = 1'b1;
            err_code_d = ERR_OVER;
          end
        end
        default: state_d = StPlay;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StPlay;
      board_q      <= '0;
      move_count_q <= 4'd0;
      game_over_q  <= 1'b0;
      winner_q     <= CELL_EMPTY;
      err_code_q   <= ERR_NONE;
      move_ok_q    <= 1'b0;
      move_err_q   <= 1'b0;
      pending_q    <= 1'b0;
      submit_q     <= 1'b0;
`ifdef TURN_CHECK_EN
      turn_q       <= FIRST_PLAYER;
`endif
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      move_count_q <= move_count_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      err_code_q   <= err_code_d;
      move_ok_q    <= move_ok_d;
      move_err_q   <= move_err_d;
      pending_q    <= pending_d;
      submit_q     <= game_reset ? 1'b0 : submit;
`ifdef TURN_CHECK_EN
      turn_q       <= turn_d;
`endif
    end
  end

  assign board      = board_q;
  assign move_ok    = move_ok_q;
  assign move_err   = move_err_q;
  assign err_code   = err_code_q;
  assign move_count = move_count_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Scoreboard bench for ttt_board_ctrl: directed moves push expected responses, a monitor checks pulses.
module tb_ttt_board_ctrl;
  import ttt_board_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  update_loc = '0;
  logic [1:0]  update_val = '0;
  logic        submit = 1'b0;
  logic        game_reset = 1'b0;
  logic [17:0] board;
  logic        move_ok, move_err;
  logic [2:0]  err_code;
  logic [3:0]  move_count;
  logic        game_over;
  logic [1:0]  winner;

  always #5 clk = ~clk;

  ttt_board_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .update_loc (update_loc),
    .update_val (update_val),
    .submit     (submit),
    .game_reset (game_reset),
    .board      (board),
    .move_ok    (move_ok),
    .move_err   (move_err),
    .err_code   (err_code),
    .move_count (move_count),
    .game_over  (game_over),
    .winner     (winner)
  );

  typedef struct {
    string       name;
    logic        ok;
    logic [2:0]  code;
    logic [17:0] brd;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [17:0] mb = '0;
  logic [3:0]  mc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every acknowledge/error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (move_ok || move_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, move_ok, move_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_ok"}, move_ok, e.ok);
        check({e.name, "_err"}, move_err, !e.ok);
        if (!e.ok) check({e.name, "_code"}, err_code, e.code);
        check({e.name, "_board"}, board, e.brd);
        check({e.name, "_count"}, move_count, e.cnt);
      end
    end
  end

  task automatic do_move(input string name, input logic [3:0] loc, input logic [1:0] val,
                         input logic [2:0] code, input int hold);
    exp_t e;
    if (code == ERR_NONE) begin
      mb[2*int'(loc) +: 2] = val;
      mc = mc + 4'd1;
    end
    e.name = name; e.ok = (code == ERR_NONE); e.code = code; e.brd = mb; e.cnt = mc;
    sb.push_back(e);
    @(negedge clk);
    update_loc = loc;
    update_val = val;
    submit     = 1'b1;
    repeat (hold) @(negedge clk);
    submit = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_game_reset();
    @(negedge clk);
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    mb = '0;
    mc = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_board"}, board, 0);
    check({tag, "_count"}, move_count, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_winner"}, winner, CELL_EMPTY);
    check({tag, "_code"}, err_code, ERR_NONE);
    check({tag, "_ok"}, move_ok, 0);
    check({tag, "_err"}, move_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle("por_in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("por");

`ifdef TURN_CHECK_EN
    do_move("x8_held", 4'd8, CELL_X, ERR_NONE, 5);
    do_move("x4_turn", 4'd4, CELL_X, ERR_TURN, 1);
    do_move("loc9_range", 4'd9, CELL_O, ERR_RANGE, 1);
    do_move("empty_value", 4'd4, CELL_EMPTY, ERR_VALUE, 1);
    do_move("o8_occupied", 4'd8, CELL_O, ERR_OCCUPIED, 1);
    check("turn_count", move_count, 1);
`else
    do_move("o0", 4'd0, CELL_O, ERR_NONE, 1);
    do_move("x0_occupied", 4'd0, CELL_X, ERR_OCCUPIED, 1);
    check("occ_code_hold", err_code, ERR_OCCUPIED);
    do_move("x8_held", 4'd8, CELL_X, ERR_NONE, 5);
    check("held_count", move_count, 2);
    do_move("loc9_range", 4'd9, CELL_X, ERR_RANGE, 1);
    do_move("loc15_range", 4'd15, CELL_O, ERR_RANGE, 1);
    do_move("empty_value", 4'd4, CELL_EMPTY, ERR_VALUE, 1);
    do_move("range_over_value", 4'd9, CELL_EMPTY, ERR_RANGE, 1);
    do_move("value_over_occ", 4'd0, 2'd3, ERR_VALUE, 1);
    check("err_board_cell0", board[1:0], CELL_O);
`endif
    do_game_reset();
    check_idle("grst1");

    // X wins across the top row.
    do_move("w_x0", 4'd0, CELL_X, ERR_NONE, 1);
    do_move("w_o3", 4'd3, CELL_O, ERR_NONE, 1);
    do_move("w_x1", 4'd1, CELL_X, ERR_NONE, 1);
    do_move("w_o4", 4'd4, CELL_O, ERR_NONE, 1);
    check("w_not_over", game_over, 0);
    do_move("w_x2", 4'd2, CELL_X, ERR_NONE, 1);
    check("w_over", game_over, 1);
    check("w_winner", winner, CELL_X);
    do_move("w_after_over", 4'd5, CELL_O, ERR_OVER, 1);
    check("w_frozen_count", move_count, 5);
    do_game_reset();
    check_idle("grst2");

    // Full board, no line.
    do_move("d_x0", 4'd0, CELL_X, ERR_NONE, 1);
    do_move("d_o1", 4'd1, CELL_O, ERR_NONE, 1);
    do_move("d_x2", 4'd2, CELL_X, ERR_NONE, 1);
    do_move("d_o4", 4'd4, CELL_O, ERR_NONE, 1);
    do_move("d_x3", 4'd3, CELL_X, ERR_NONE, 1);
    do_move("d_o5", 4'd5, CELL_O, ERR_NONE, 1);
    do_move("d_x7", 4'd7, CELL_X, ERR_NONE, 1);
    do_move("d_o6", 4'd6, CELL_O, ERR_NONE, 1);
    check("d_not_over", game_over, 0);
    do_move("d_x8", 4'd8, CELL_X, ERR_NONE, 1);
    check("d_count", move_count, 9);
    check("d_over", game_over, 1);
    check("d_winner", winner, CELL_EMPTY);
    do_game_reset();
    check_idle("grst3");

    // O wins down the middle column.
    do_move("o_x0", 4'd0, CELL_X, ERR_NONE, 1);
    do_move("o_o1", 4'd1, CELL_O, ERR_NONE, 1);
    do_move("o_x3", 4'd3, CELL_X, ERR_NONE, 1);
    do_move("o_o4", 4'd4, CELL_O, ERR_NONE, 1);
    do_move("o_x8", 4'd8, CELL_X, ERR_NONE, 1);
    do_move("o_o7", 4'd7, CELL_O, ERR_NONE, 1);
    check("o_over", game_over, 1);
    check("o_winner", winner, CELL_O);

    // game_reset together with a submit edge: reset wins, no move is taken.
    @(negedge clk);
    game_reset = 1'b1;
    update_loc = 4'd2;
    update_val = CELL_X;
    submit     = 1'b1;
    @(negedge clk);
    check_idle("grst_edge");
    game_reset = 1'b0;
    submit     = 1'b0;
    mb = '0;
    mc = '0;
    @(negedge clk);
    check_idle("grst_edge_after");

    // Asynchronous reset while the FSM is in CHECK.
    @(negedge clk);
    update_loc = 4'd4;
    update_val = CELL_X;
    submit     = 1'b1;
    @(posedge clk);
    #2;
    check("pre_async_ok", move_ok, 1);
    reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    submit = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("after_async");

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
